// File: rtl/mor1kx_pic_sched_if.sv
// ---------------------------------------------------------------------------
// mor1kx_pic_sched_if
// Signal bundle between the PIC register block / CPU exception unit (master
// side) and the interrupt scheduler (slave side).
//
// Handshake: irq_o acts as "valid" and exc_taken_i as "ready/ack". While
// irq_o is high, irq_id_o is stable. A request is consumed only on a clock
// edge where irq_o and exc_taken_i are both 1. exc_taken_i sampled while
// irq_o is low has no effect. irq_o may drop without an ack only when the
// line is withdrawn or the ack timeout expires.
//
// Signals:
//   pending_i    [31:0] pending interrupt lines (PICSR)
//   irq_en_i            CPU interrupt enable (SR[IEE])
//   exc_taken_i         CPU took the interrupt exception (ack)
//   eoi_i               end-of-interrupt strobe
//   eoi_id_i     [4:0]  ID being retired
//   irq_o               interrupt request to the CPU
//   irq_id_o     [4:0]  ID of the requested / in-service line
//   in_service_o [31:0] one-hot in-service line, or 0
//   timeout_o           one-cycle pulse: request withdrawn on timeout
//   eoi_err_o           one-cycle pulse: EOI ignored
//   state_dbg_o  [1:0]  scheduler FSM state (debug/observability)
// ---------------------------------------------------------------------------
interface mor1kx_pic_sched_if;
  logic [31:0] pending_i;
  logic        irq_en_i;
  logic        exc_taken_i;
  logic        eoi_i;
  logic [4:0]  eoi_id_i;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic [31:0] in_service_o;
  logic        timeout_o;
  logic        eoi_err_o;
  logic [1:0]  state_dbg_o;

  modport slave (
    input  pending_i, irq_en_i, exc_taken_i, eoi_i, eoi_id_i,
    output irq_o, irq_id_o, in_service_o, timeout_o, eoi_err_o, state_dbg_o
  );

  modport master (
    output pending_i, irq_en_i, exc_taken_i, eoi_i, eoi_id_i,
    input  irq_o, irq_id_o, in_service_o, timeout_o, eoi_err_o, state_dbg_o
  );
endinterface

// File: rtl/mor1kx_pic_sched.sv
// ---------------------------------------------------------------------------
// mor1kx_pic_sched
// Interrupt scheduler between the PIC status/mask registers and the CPU
// exception unit. Picks one eligible pending line while idle, presents it as a
// registered request (irq_o / irq_id_o), and tracks it as in-service until a
// matching end-of-interrupt. Only one interrupt is in service at a time.
// Lines below OPTION_PIC_NMI_WIDTH ignore the CPU interrupt enable.
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   mor1kx_pic_sched_if.slave (pending/enable/ack/EOI in,
//         request/ID/in-service/timeout/eoi-error/debug-state out)
//
// Parameters:
//   OPTION_PIC_NMI_WIDTH  number of low-index non-maskable lines
//   OPTION_ACK_TIMEOUT    REQ cycles before the request is withdrawn (0 = off)
//
// Build option:
//   MOR1KX_PIC_SCHED_RR_EN  when defined, round-robin arbitration with a
//                           5-bit pointer (last granted + 1); otherwise fixed
//                           lowest-index priority.
// ---------------------------------------------------------------------------
module mor1kx_pic_sched #(
  parameter int OPTION_PIC_NMI_WIDTH = 0,
  parameter int OPTION_ACK_TIMEOUT   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  mor1kx_pic_sched_if.slave        bus
);

  localparam int            CW         = (OPTION_ACK_TIMEOUT > 1) ? $clog2(OPTION_ACK_TIMEOUT) : 1;
  localparam bit            TIMEOUT_EN = (OPTION_ACK_TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST   = TIMEOUT_EN ? CW'(OPTION_ACK_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_irq;
  logic [4:0]    r_irq_id;
  logic [31:0]   r_in_service;
  logic          r_timeout;
  logic          r_eoi_err;
  logic [CW-1:0] r_cnt;

  logic [31:0]   w_nmi_mask;
  logic [31:0]   w_eligible;
  logic          w_any;
  logic [4:0]    w_winner;

  logic          w_ack;
  logic          w_withdraw;
  logic          w_timeout_hit;
  logic          w_eoi_match;

  logic          w_irq_nxt;
  logic [4:0]    w_irq_id_nxt;
  logic [31:0]   w_in_service_nxt;
  logic          w_timeout_nxt;
  logic          w_eoi_err_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // -------------------------------------------------------------------------
  // Eligibility: NMI lines bypass the CPU interrupt enable
  // -------------------------------------------------------------------------
  always_comb begin
    w_nmi_mask = '0;
    for (int i = 0; i < 32; i++) begin
      w_nmi_mask[i] = (i < OPTION_PIC_NMI_WIDTH);
    end
  end

  assign w_eligible = bus.pending_i & ({32{bus.irq_en_i}} | w_nmi_mask);
  assign w_any      = |w_eligible;

  // -------------------------------------------------------------------------
  // Arbiter
  // -------------------------------------------------------------------------
`ifdef MOR1KX_PIC_SCHED_RR_EN
  logic [4:0] r_ptr;
  logic [4:0] w_ptr_nxt;

  // Descending loops let the lowest offset from the pointer win; the second
  // loop then lets the lowest eligible NMI line override the rotation.
  always_comb begin
    w_winner = '0;
    for (int k = 31; k >= 0; k--) begin
      logic [4:0] idx;
      idx = r_ptr + 5'(k);
      if (w_eligible[idx]) begin
        w_winner = idx;
      end
    end
    for (int i = 31; i >= 0; i--) begin
      if (w_eligible[i] && w_nmi_mask[i]) begin
        w_winner = 5'(i);
      end
    end
  end

  // Pointer moves only when a grant is actually taken by the CPU.
  assign w_ptr_nxt = (r_state == S_REQ && w_ack) ? (r_irq_id + 5'd1) : r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  always_comb begin
    w_winner = '0;
    for (int i = 31; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = 5'(i);
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Event decode (priority inside REQ: ack > withdraw > timeout)
  // -------------------------------------------------------------------------
  assign w_ack         = bus.exc_taken_i;
  assign w_withdraw    = ~bus.pending_i[r_irq_id];
  assign w_timeout_hit = TIMEOUT_EN && (r_cnt == CNT_LAST);
  assign w_eoi_match   = bus.eoi_i && (bus.eoi_id_i == r_irq_id);

  // -------------------------------------------------------------------------
  // FSM: state register (plus the registered outputs it drives)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_irq        <= 1'b0;
      r_irq_id     <= '0;
      r_in_service <= '0;
      r_timeout    <= 1'b0;
      r_eoi_err    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_irq        <= w_irq_nxt;
      r_irq_id     <= w_irq_id_nxt;
      r_in_service <= w_in_service_nxt;
      r_timeout    <= w_timeout_nxt;
      r_eoi_err    <= w_eoi_err_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_ack) begin
          w_state_nxt = S_SERVICE;
        end else if (w_withdraw) begin
          w_state_nxt = S_IDLE;
        end else if (w_timeout_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (w_eoi_match) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic (next values for the registered outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    w_irq_nxt        = (w_state_nxt == S_REQ);
    w_irq_id_nxt     = r_irq_id;
    w_in_service_nxt = r_in_service;
    w_timeout_nxt    = 1'b0;
    w_eoi_err_nxt    = 1'b0;
    w_cnt_nxt        = '0;

    if (r_state == S_IDLE && w_any) begin
      w_irq_id_nxt = w_winner;
    end

    if (r_state == S_REQ && w_ack) begin
      w_in_service_nxt = 32'h1 << r_irq_id;
    end else if (r_state == S_SERVICE && w_eoi_match) begin
      w_in_service_nxt = '0;
    end

    if (r_state == S_REQ && !w_ack && !w_withdraw && w_timeout_hit) begin
      w_timeout_nxt = 1'b1;
    end

    // Any EOI that does not retire the in-service line is dropped and flagged.
    if (bus.eoi_i && !(r_state == S_SERVICE && w_eoi_match)) begin
      w_eoi_err_nxt = 1'b1;
    end

    // Counter runs only while a request stays outstanding; entering REQ
    // from IDLE always starts it from zero.
    if (r_state == S_REQ && w_state_nxt == S_REQ) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  assign bus.irq_o        = r_irq;
  assign bus.irq_id_o     = r_irq_id;
  assign bus.in_service_o = r_in_service;
  assign bus.timeout_o    = r_timeout;
  assign bus.eoi_err_o    = r_eoi_err;
  assign bus.state_dbg_o  = r_state;

endmodule

// File: tb/tb_mor1kx_pic_sched.sv
// ---------------------------------------------------------------------------
// tb_mor1kx_pic_sched
// Bench for mor1kx_pic_sched with two non-maskable lines and a four-cycle ack
// timeout. Directed vector table, a round-robin grant sequence (when
// MOR1KX_PIC_SCHED_RR_EN is defined) and random traffic against a
// behavioural model.
// ---------------------------------------------------------------------------
module tb_mor1kx_pic_sched;

  localparam int          TB_NMI     = 2;
  localparam int          TB_TIMEOUT = 4;
  localparam logic [31:0] NMI_MASK   = (32'h1 << TB_NMI) - 32'h1;
`ifdef MOR1KX_PIC_SCHED_RR_EN
  // After granting 8, the rotation resumes at 9 so line 10 is next.
  localparam logic [4:0]  RE = 5'd10;
`else
  localparam logic [4:0]  RE = 5'd8;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mor1kx_pic_sched_if bus();

  mor1kx_pic_sched #(
    .OPTION_PIC_NMI_WIDTH (TB_NMI),
    .OPTION_ACK_TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  // phase: 0 = nothing outstanding, 1 = requesting, 2 = in service
  int         m_phase = 0;
  logic [4:0] m_id    = '0;
  logic [4:0] m_ptr   = '0;
  int         m_age   = 0;
  logic       m_to    = 1'b0;
  logic       m_err   = 1'b0;

  // NMI lines first (lowest index), then a wrap-around search from the
  // pointer. With round-robin disabled the pointer stays 0, which is plain
  // lowest-index priority.
  function automatic logic [4:0] m_pick(input logic [31:0] elig, input logic [4:0] ptr);
    for (int i = 0; i < TB_NMI; i++) begin
      if (elig[i]) return 5'(i);
    end
    for (int k = 0; k < 32; k++) begin
      int j;
      j = (int'(ptr) + k) % 32;
      if (elig[j]) return 5'(j);
    end
    return 5'd0;
  endfunction

  task automatic model_edge(input logic r, input logic [31:0] p, input logic en,
                            input logic exc, input logic eoi, input logic [4:0] eid);
    logic [31:0] elig;
    m_to  = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_phase = 0;
      m_id    = '0;
      m_ptr   = '0;
      m_age   = 0;
      return;
    end
    m_err = eoi && !(m_phase == 2 && eid == m_id);
    elig  = p & (en ? 32'hFFFF_FFFF : NMI_MASK);
    if (m_phase == 0) begin
      if (elig != 0) begin
        m_phase = 1;
        m_id    = m_pick(elig, m_ptr);
        m_age   = 0;
      end
    end else if (m_phase == 1) begin
      if (exc) begin
        m_phase = 2;
`ifdef MOR1KX_PIC_SCHED_RR_EN
        m_ptr = m_id + 5'd1;
`endif
      end else if (!p[m_id]) begin
        m_phase = 0;
      end else if (TB_TIMEOUT > 0 && m_age == TB_TIMEOUT - 1) begin
        m_phase = 0;
        m_to    = 1'b1;
      end else begin
        m_age++;
      end
    end else begin
      if (eoi && eid == m_id) m_phase = 0;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive inputs, advance the model, wait for the next
  // negedge so outputs are sampled half a cycle after the active edge.
  task automatic cycle(input logic r, input logic [31:0] p, input logic en,
                       input logic exc, input logic eoi, input logic [4:0] eid);
    rst             = r;
    bus.pending_i   = p;
    bus.irq_en_i    = en;
    bus.exc_taken_i = exc;
    bus.eoi_i       = eoi;
    bus.eoi_id_i    = eid;
    model_edge(r, p, en, exc, eoi, eid);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [31:0] pend;
    logic        en;
    logic        exc;
    logic        eoi;
    logic [4:0]  eid;
    logic        e_irq;
    logic        chk_id;
    logic [4:0]  e_id;
    logic [31:0] e_isv;
    logic        e_to;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [31:0] p, input logic en,
                              input logic exc, input logic eoi, input logic [4:0] eid,
                              input logic e_irq, input logic chk_id, input logic [4:0] e_id,
                              input logic [31:0] e_isv, input logic e_to, input logic e_err);
    vec_t v;
    v.rst = r;  v.pend = p;  v.en = en;  v.exc = exc;  v.eoi = eoi;  v.eid = eid;
    v.e_irq = e_irq;  v.chk_id = chk_id;  v.e_id = e_id;  v.e_isv = e_isv;
    v.e_to = e_to;  v.e_err = e_err;
    return v;
  endfunction

  // ---------------- scoreboard for grant order ----------------
  logic [4:0] exp_q[$];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs[$];
    logic [31:0] r_pend;
    logic        r_rst, r_en, r_exc, r_eoi;
    logic [4:0]  r_eid;

    bus.pending_i   = '0;
    bus.irq_en_i    = 1'b0;
    bus.exc_taken_i = 1'b0;
    bus.eoi_i       = 1'b0;
    bus.eoi_id_i    = '0;
    @(negedge clk);

    //              rst pend          en exc eoi eid    irq chk id  isv            to err
    vecs.push_back(mk(1, 32'h0,        0, 0, 0, 5'd0,  0, 1, 5'd0, 32'h0,        0, 0)); // reset
    vecs.push_back(mk(0, 32'h0,        1, 0, 0, 5'd0,  0, 1, 5'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h500,      1, 0, 0, 5'd0,  1, 1, 5'd8, 32'h0,        0, 0)); // lowest of 8,10
    vecs.push_back(mk(0, 32'h500,      1, 1, 0, 5'd0,  0, 1, 5'd8, 32'h100,      0, 0)); // ack
    vecs.push_back(mk(0, 32'h500,      1, 0, 0, 5'd0,  0, 1, 5'd8, 32'h100,      0, 0)); // holds
    vecs.push_back(mk(0, 32'h500,      1, 0, 1, 5'd8,  0, 0, 5'd0, 32'h0,        0, 0)); // EOI 8
    vecs.push_back(mk(0, 32'h500,      1, 0, 0, 5'd0,  1, 1, RE,   32'h0,        0, 0)); // re-request
    vecs.push_back(mk(0, 32'h500,      1, 1, 0, 5'd0,  0, 1, RE,   32'h1 << RE,  0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 1, RE,    0, 0, 5'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h12,       0, 0, 0, 5'd0,  1, 1, 5'd1, 32'h0,        0, 0)); // NMI line 1
    vecs.push_back(mk(0, 32'h12,       0, 1, 0, 5'd0,  0, 1, 5'd1, 32'h2,        0, 0));
    vecs.push_back(mk(0, 32'h10,       0, 0, 1, 5'd1,  0, 0, 5'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h10,       0, 0, 0, 5'd0,  0, 0, 5'd0, 32'h0,        0, 0)); // masked
    vecs.push_back(mk(0, 32'h10,       0, 0, 0, 5'd0,  0, 0, 5'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h8,        1, 0, 0, 5'd0,  1, 1, 5'd3, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 0, 5'd0,  0, 0, 5'd0, 32'h0,        0, 0)); // withdraw
    vecs.push_back(mk(0, 32'h8,        1, 0, 0, 5'd0,  1, 1, 5'd3, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 0, 5'd0,  0, 1, 5'd3, 32'h8,        0, 0)); // ack beats withdraw
    vecs.push_back(mk(0, 32'h0,        1, 0, 1, 5'd3,  0, 0, 5'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h40,       1, 0, 0, 5'd0,  1, 1, 5'd6, 32'h0,        0, 0)); // REQ cycle 1
    vecs.push_back(mk(0, 32'h40,       1, 0, 0, 5'd0,  1, 1, 5'd6, 32'h0,        0, 0)); // 2
    vecs.push_back(mk(0, 32'h40,       1, 0, 0, 5'd0,  1, 1, 5'd6, 32'h0,        0, 0)); // 3
    vecs.push_back(mk(0, 32'h40,       1, 0, 0, 5'd0,  1, 1, 5'd6, 32'h0,        0, 0)); // 4
    vecs.push_back(mk(0, 32'h40,       1, 0, 0, 5'd0,  0, 0, 5'd0, 32'h0,        1, 0)); // timeout
    vecs.push_back(mk(0, 32'h40,       1, 0, 0, 5'd0,  1, 1, 5'd6, 32'h0,        0, 0)); // re-request
    vecs.push_back(mk(0, 32'h40,       1, 0, 1, 5'd6,  1, 1, 5'd6, 32'h0,        0, 1)); // EOI in REQ
    vecs.push_back(mk(0, 32'h40,       1, 1, 0, 5'd0,  0, 1, 5'd6, 32'h40,       0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 1, 5'd6,  0, 0, 5'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h20,       1, 0, 0, 5'd0,  1, 1, 5'd5, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h20,       1, 1, 0, 5'd0,  0, 1, 5'd5, 32'h20,       0, 0));
    vecs.push_back(mk(0, 32'h20,       1, 0, 1, 5'd6,  0, 1, 5'd5, 32'h20,       0, 1)); // wrong EOI id
    vecs.push_back(mk(0, 32'h20,       1, 0, 0, 5'd0,  0, 1, 5'd5, 32'h20,       0, 0));
    vecs.push_back(mk(1, 32'h20,       1, 0, 0, 5'd0,  0, 1, 5'd0, 32'h0,        0, 0)); // reset in SERVICE
    vecs.push_back(mk(0, 32'h0,        1, 0, 0, 5'd0,  0, 1, 5'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 1, 5'd0,  0, 1, 5'd0, 32'h0,        0, 1)); // EOI in IDLE
    vecs.push_back(mk(0, 32'h0,        1, 0, 0, 5'd0,  0, 1, 5'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h4,        1, 0, 0, 5'd0,  1, 1, 5'd2, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h4,        0, 0, 0, 5'd0,  1, 1, 5'd2, 32'h0,        0, 0)); // enable drop keeps req
    vecs.push_back(mk(0, 32'h4,        0, 1, 0, 5'd0,  0, 1, 5'd2, 32'h4,        0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 1, 5'd2,  0, 0, 5'd0, 32'h0,        0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].pend, vecs[i].en, vecs[i].exc, vecs[i].eoi, vecs[i].eid);
      check($sformatf("vec%0d_irq", i), 32'(bus.irq_o), 32'(vecs[i].e_irq));
      if (vecs[i].chk_id)
        check($sformatf("vec%0d_id", i), 32'(bus.irq_id_o), 32'(vecs[i].e_id));
      check($sformatf("vec%0d_in_service", i), bus.in_service_o, vecs[i].e_isv);
      check($sformatf("vec%0d_timeout", i), 32'(bus.timeout_o), 32'(vecs[i].e_to));
      check($sformatf("vec%0d_eoi_err", i), 32'(bus.eoi_err_o), 32'(vecs[i].e_err));
    end

`ifdef MOR1KX_PIC_SCHED_RR_EN
    // Lines 2, 3 and 31 held pending: the rotation must wrap from 31 to 2.
    exp_q = {5'd2, 5'd3, 5'd31, 5'd2, 5'd3};
    cycle(1, 32'h0, 1, 0, 0, 5'd0);
    while (exp_q.size() > 0) begin
      logic [4:0] e;
      int         waited;
      e      = exp_q.pop_front();
      waited = 0;
      while (!bus.irq_o && waited < 8) begin
        cycle(0, 32'h8000_000C, 1, 0, 0, 5'd0);
        waited++;
      end
      check("rr_grant_valid", 32'(bus.irq_o), 32'h1);
      check("rr_grant_id", 32'(bus.irq_id_o), 32'(e));
      cycle(0, 32'h8000_000C, 1, 1, 0, 5'd0);
      check("rr_in_service", bus.in_service_o, 32'h1 << e);
      cycle(0, 32'h8000_000C, 1, 0, 1, e);
    end
`endif

    // ---------------- random traffic vs model ----------------
    r_pend = '0;
    cycle(1, 32'h0, 0, 0, 0, 5'd0);
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0)
        r_pend = $urandom() & $urandom() & $urandom();
      r_en  = ($urandom_range(0, 4) != 0);
      r_exc = ($urandom_range(0, 4) == 0);
      r_eoi = ($urandom_range(0, 4) == 0);
      r_eid = ($urandom_range(0, 9) < 7) ? m_id : 5'($urandom_range(0, 31));
      cycle(r_rst, r_pend, r_en, r_exc, r_eoi, r_eid);
      check("rnd_irq", 32'(bus.irq_o), 32'(m_phase == 1));
      if (m_phase != 0)
        check("rnd_id", 32'(bus.irq_id_o), 32'(m_id));
      check("rnd_in_service", bus.in_service_o, (m_phase == 2) ? (32'h1 << m_id) : 32'h0);
      check("rnd_timeout", 32'(bus.timeout_o), 32'(m_to));
      check("rnd_eoi_err", 32'(bus.eoi_err_o), 32'(m_err));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mor1kx_pic_sched.md
Name: mor1kx_pic_sched

Overview:
Interrupt scheduler that sits between the PIC status/mask registers and the CPU exception unit. Each cycle it takes the pending vector (PICSR output) and selects one line. It presents that line to the CPU as a registered request with its 5-bit ID, and tracks the line as in-service until software signals end-of-interrupt (EOI). Only one interrupt is in service at a time. Lines below OPTION_PIC_NMI_WIDTH bypass the CPU interrupt-enable gate.

Parameters:
OPTION_PIC_NMI_WIDTH, 0, number of low-index lines treated as non-maskable (ignore irq_en_i)
OPTION_ACK_TIMEOUT, 0, cycles allowed in REQ before the request is withdrawn; 0 = no timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pending_i  in  32  pending interrupt lines (PICSR)
irq_en_i  in  1  CPU interrupt enable (SR[IEE])
exc_taken_i  in  1  CPU has taken the interrupt exception (ack)
eoi_i  in  1  end-of-interrupt strobe
eoi_id_i  in  5  ID being retired by the EOI
irq_o  out  1  interrupt request to CPU
irq_id_o  out  5  ID of requested / in-service line
in_service_o  out  32  one-hot in-service line, or 0
timeout_o  out  1  one-cycle pulse: request withdrawn on timeout
eoi_err_o  out  1  one-cycle pulse: EOI ignored

Behaviour:
- Reset values: state IDLE; irq_o, irq_id_o, in_service_o, timeout_o and eoi_err_o all 0; rr pointer 0; timeout counter 0.
- eligible[i] = pending_i[i] & (irq_en_i | (i < OPTION_PIC_NMI_WIDTH)).
- Arbitration happens only in IDLE. Default policy is fixed priority: the lowest index wins.
- FSM states: IDLE, REQ, SERVICE.
- IDLE -> REQ:
  - Transition when eligible != 0 at edge N.
  - irq_id_o latches the winner; irq_o = 1 from cycle N+1 (one-cycle latency, fully registered).
- REQ:
  - If exc_taken_i = 1: go to SERVICE. Set in_service_o[irq_id_o]; irq_o = 0 next cycle.
  - Else if pending_i[irq_id_o] = 0 (line withdrawn): go to IDLE, irq_o = 0 next cycle. No error is flagged.
  - Else if OPTION_ACK_TIMEOUT > 0 and the counter equals OPTION_ACK_TIMEOUT-1: go to IDLE, irq_o = 0, timeout_o pulses one cycle.
  - Priority when events coincide: ack > withdraw > timeout.
  - The counter clears on entering REQ and increments each REQ cycle without ack.
- SERVICE:
  - irq_o = 0; irq_id_o holds.
  - eoi_i with eoi_id_i == irq_id_o: go to IDLE next edge and clear in_service_o.
  - eoi_i with a mismatched ID: ignored, eoi_err_o pulse.
- eoi_i in IDLE or REQ: ignored, eoi_err_o pulse.
- Re-arbitration can occur in the cycle after returning to IDLE, so the minimum gap between successive irq_o assertions is 1 cycle of irq_o = 0.
- irq_en_i dropping while in REQ does not withdraw the request; the CPU gates it.
- Reset mid-operation returns all state to reset values the next edge, regardless of state.

Optional Feature:
- Macro: MOR1KX_PIC_SCHED_RR_EN.
- Defined: round-robin arbitration.
  - A 5-bit pointer holds last_granted+1 mod 32.
  - The search starts at the pointer and wraps 31 -> 0.
  - The pointer updates only on the REQ -> SERVICE transition, not on withdraw or timeout.
  - NMI lines (index < OPTION_PIC_NMI_WIDTH) always preempt the round-robin order; lowest NMI index first.
- Undefined: fixed lowest-index priority; no pointer register.

Test Plan:
- Fixed priority, irq_en_i = 1, pending_i = 0x00000500 at edge N -> irq_o = 1, irq_id_o = 8 at N+1; exc_taken_i pulse -> in_service_o = 0x00000100, irq_o = 0; eoi_i with id 8 -> in_service_o = 0; with pending still 0x500, irq_id_o = 8 re-requested after one idle cycle.
- irq_en_i = 0, OPTION_PIC_NMI_WIDTH = 2, pending_i = 0x00000012 -> irq_o = 1, irq_id_o = 1; pending_i = 0x10 alone -> irq_o stays 0.
- In REQ with id 3, drop pending_i[3] -> irq_o = 0 next cycle, timeout_o = 0, eoi_err_o = 0; ack and withdraw in the same cycle -> SERVICE with in_service_o = 0x8.
- OPTION_ACK_TIMEOUT = 4, no ack -> irq_o high exactly 4 cycles, timeout_o single pulse, then re-request of the same ID.
- In SERVICE with id 5, eoi_i with id 6 -> eoi_err_o pulse, in_service_o = 0x20 unchanged; rst asserted in SERVICE -> all outputs 0 next cycle.
- MOR1KX_PIC_SCHED_RR_EN, pending_i = 0x80000003 held, each grant acked and EOI'd -> grant sequence 0, 1, 31, 0, 1 (pointer wraps 31 -> 0).
